// File: rtl/ope_pkg.sv
// Shared types and helpers for the outer-product stream engine.
// Optional row-sum beats are enabled by defining OPE_ROW_SUM_EN.
package ope_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    WAIT_A = 2'd2,
    CALC   = 2'd3
  } state_t;

  // Counter width for n values; never narrower than one bit.
  function automatic int ope_min1_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ope_beats(input int len, input int pack);
    return len / pack;
  endfunction

  // Unsigned add clamped to the largest w-bit value.
  function automatic logic [31:0] ope_sat_add(input logic [31:0] a, input logic [31:0] b,
                                              input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      return lim[31:0];
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/ope_out_stage.sv
// Single-entry output register for the outer-product engine: loads on issue,
// holds while the downstream FIFO is full, clears after a completed transfer.
module ope_out_stage #(
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_full,
  input  logic          issue,
  input  logic [OW-1:0] issue_data,
  input  logic          issue_last,
  input  logic          issue_is_sum,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          out_is_sum
);

  // Output beat register with hold-on-full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_is_sum <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_data   <= issue_data;
      out_last   <= issue_last;
      out_is_sum <= issue_is_sum;
    end else if (out_valid && fifo_full) begin
      out_valid  <= out_valid;
      out_data   <= out_data;
      out_last   <= out_last;
      out_is_sum <= out_is_sum;
    end else begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_is_sum <= 1'b0;
    end
  end

endmodule

// File: rtl/outer_product_stream_engine.sv
// Loads vector B, then streams A in PACK-wide beats and emits every A[i]*B[j]
// row-major into a FIFO. Define OPE_ROW_SUM_EN to append a saturated row-sum beat per row.
module outer_product_stream_engine
  import ope_pkg::*;
#(
  parameter int LEN  = 16,
  parameter int DW   = 4,
  parameter int PACK = 2,
  localparam int OW  = 2 * DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PACK*DW-1:0] in_data,
  output logic               in_ready,
  input  logic               fifo_full,
  output logic               out_valid,
  output logic [OW-1:0]      out_data,
  output logic               out_last,
  output logic               out_is_sum,
  output logic               busy
);

  localparam int BEATS = ope_beats(LEN, PACK);
  localparam int CW    = ope_min1_clog2(LEN);
  localparam int PW    = ope_min1_clog2(PACK);
  localparam int BW    = ope_min1_clog2(BEATS);

  state_t          state_r;
  state_t          state_nxt;
  logic [DW-1:0]   b_buf_r [LEN];
  logic [DW-1:0]   a_buf_r [PACK];
  logic [BW-1:0]   beat_r;
  logic [PW-1:0]   p_r;
  logic [CW-1:0]   j_r;
  logic [CW-1:0]   base_s;
  logic            accept_s;
  logic            issue_s;
  logic            row_end_s;
  logic            beat_end_s;
  logic            final_s;
  logic [OW-1:0]   prod_s;
  logic [OW-1:0]   issue_data_s;
  logic            issue_is_sum_s;

  assign in_ready  = (state_r != CALC);
  assign accept_s  = in_valid && in_ready;
  assign issue_s   = (state_r == CALC) && (!out_valid || !fifo_full);
  assign busy      = (state_r == CALC) || out_valid;
  assign base_s    = CW'(int'(beat_r) * PACK);
  assign prod_s    = OW'(a_buf_r[p_r]) * OW'(b_buf_r[j_r]);

`ifdef OPE_ROW_SUM_EN
  logic          sum_slot_r;
  logic [OW-1:0] acc_r;

  assign row_end_s      = sum_slot_r;
  assign issue_data_s   = sum_slot_r ? acc_r : prod_s;
  assign issue_is_sum_s = sum_slot_r;
`else
  assign row_end_s      = (j_r == CW'(LEN - 1));
  assign issue_data_s   = prod_s;
  assign issue_is_sum_s = 1'b0;
`endif

  assign beat_end_s = row_end_s && (p_r == PW'(PACK - 1));
  assign final_s    = beat_end_s && (beat_r == BW'(BEATS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; in_ready is high in every state but CALC.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt = (BEATS == 1) ? WAIT_A : LOAD_B;
        else          state_nxt = IDLE;
      end
      LOAD_B: begin
        if (in_valid && (beat_r == BW'(BEATS - 1))) state_nxt = WAIT_A;
        else                                        state_nxt = LOAD_B;
      end
      WAIT_A: begin
        if (in_valid) state_nxt = CALC;
        else          state_nxt = WAIT_A;
      end
      CALC: begin
        if (issue_s && beat_end_s) state_nxt = final_s ? IDLE : WAIT_A;
        else                       state_nxt = CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector buffers and the beat / element / column sequencing counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LEN; k++) b_buf_r[k] <= '0;
      for (int k = 0; k < PACK; k++) a_buf_r[k] <= '0;
      beat_r <= '0;
      p_r    <= '0;
      j_r    <= '0;
`ifdef OPE_ROW_SUM_EN
      sum_slot_r <= 1'b0;
      acc_r      <= '0;
`endif
    end else begin
      case (state_r)
        IDLE, LOAD_B: begin
          if (accept_s) begin
            for (int k = 0; k < PACK; k++) b_buf_r[base_s + CW'(k)] <= in_data[k*DW +: DW];
            beat_r <= (beat_r == BW'(BEATS - 1)) ? '0 : beat_r + BW'(1);
          end
        end
        WAIT_A: begin
          if (accept_s) begin
            for (int k = 0; k < PACK; k++) a_buf_r[k] <= in_data[k*DW +: DW];
            p_r <= '0;
            j_r <= '0;
          end
        end
        CALC: begin
          if (issue_s) begin
`ifdef OPE_ROW_SUM_EN
            if (sum_slot_r) begin
              sum_slot_r <= 1'b0;
              acc_r      <= '0;
            end else begin
              acc_r <= OW'(ope_sat_add(32'(acc_r), 32'(prod_s), OW));
              if (j_r == CW'(LEN - 1)) begin
                j_r        <= '0;
                sum_slot_r <= 1'b1;
              end else begin
                j_r <= j_r + CW'(1);
              end
            end
`else
            j_r <= (j_r == CW'(LEN - 1)) ? '0 : j_r + CW'(1);
`endif
            if (row_end_s) begin
              if (p_r == PW'(PACK - 1)) begin
                p_r    <= '0;
                beat_r <= final_s ? '0 : beat_r + BW'(1);
              end else begin
                p_r <= p_r + PW'(1);
              end
            end
          end
        end
        default: beat_r <= '0;
      endcase
    end
  end

  ope_out_stage #(.OW(OW)) u_out_stage (
    .clk          (clk),
    .rst          (rst),
    .fifo_full    (fifo_full),
    .issue        (issue_s),
    .issue_data   (issue_data_s),
    .issue_last   (final_s),
    .issue_is_sum (issue_is_sum_s),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_is_sum   (out_is_sum)
  );

endmodule

// File: tb/tb_outer_product_stream_engine.sv
// Directed bench for outer_product_stream_engine (LEN=16, DW=4, PACK=2);
// row-sum expectations are used when OPE_ROW_SUM_EN is defined.
module tb_outer_product_stream_engine;

  localparam int LEN = 16;
`ifdef OPE_ROW_SUM_EN
  localparam int NB = LEN * (LEN + 1);
`else
  localparam int NB = LEN * LEN;
`endif
  localparam int G = NB / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       fifo_full;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_is_sum;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hold_err = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int stamp_q[$];
  logic [3:0] vb[16];
  logic [3:0] va[16];
  bit abort = 1'b0;
  bit rand_full = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  outer_product_stream_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_full(fifo_full), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_is_sum(out_is_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Collector: a beat sampled valid and not-full at the falling edge transfers next rising edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!out_valid || out_data !== prev_data)) hold_err++;
      if (out_valid && !fifo_full) begin
        got_q.push_back({out_last, out_is_sum, out_data});
        stamp_q.push_back(cyc);
      end
      prev_hold = out_valid && fifo_full;
      prev_data = out_data;
    end
  end

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    stamp_q.delete();
    hold_err = 0;
  endtask

  task automatic build_exp();
    int sum;
    int p;
    for (int i = 0; i < 16; i++) begin
      sum = 0;
      for (int j = 0; j < 16; j++) begin
        p = int'(va[i]) * int'(vb[j]);
        sum += p;
`ifdef OPE_ROW_SUM_EN
        exp_q.push_back({1'b0, 1'b0, 8'(p)});
`else
        exp_q.push_back({(i == 15 && j == 15), 1'b0, 8'(p)});
`endif
      end
`ifdef OPE_ROW_SUM_EN
      exp_q.push_back({(i == 15), 1'b1, (sum > 255) ? 8'd255 : 8'(sum)});
`endif
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 16; k++) begin
      vb[k] = 4'(k);
      va[k] = 4'(k);
    end
  endtask

  task automatic set_max();
    for (int k = 0; k < 16; k++) begin
      vb[k] = 4'd15;
      va[k] = 4'd15;
    end
  endtask

  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && !abort && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (abort) begin
      in_valid = 1'b0;
      return;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'd0;
  endtask

  task automatic send_b();
    for (int k = 0; k < 8; k++) if (!abort) send_beat({vb[2*k+1], vb[2*k]});
  endtask

  task automatic send_a(input int first, input int last);
    for (int k = first; k <= last; k++) if (!abort) send_beat({va[2*k+1], va[2*k]});
  endtask

  task automatic wait_done(input int n);
    int c;
    c = 0;
    while ((got_q.size() < n || busy) && c < 20000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 20000) begin
      total++;
      bad++;
      $display("FAIL wait_timeout beats=%0d required=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL rst_data got=%0d exp=0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", out_last); end
    total++; if (out_is_sum !== 1'b0) begin bad++; $display("FAIL rst_is_sum got=%b exp=0", out_is_sum); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_max();
    int nf;
    int gaps;
    clear_all();
    set_max();
    build_exp();
    send_b();
    send_a(0, 7);
    wait_done(NB);
    total++;
    if (got_q.size() !== NB) begin bad++; $display("FAIL max_count got=%0d exp=%0d", got_q.size(), NB); end
    nf = 0;
    for (int n = 0; n < NB && n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== exp_q[n]) begin
        bad++;
        if (nf++ < 4) $display("FAIL max_beat n=%0d got=%h exp=%h", n, got_q[n], exp_q[n]);
      end
    end
    gaps = 0;
    for (int n = 1; n < stamp_q.size(); n++) if ((n % G) != 0 && stamp_q[n] - stamp_q[n-1] != 1) gaps++;
    total++; if (gaps !== 0) begin bad++; $display("FAIL max_consecutive gaps=%0d exp=0", gaps); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL max_idle in_ready=%b exp=1", in_ready); end
`ifdef OPE_ROW_SUM_EN
    total++;
    if (got_q[16] !== {2'b01, 8'd255}) begin bad++; $display("FAIL max_sat got=%h exp=0ff", got_q[16]); end
`endif
  endtask

  task automatic test_ramp();
    int nf;
    clear_all();
    set_ramp();
    build_exp();
    send_b();
    send_a(0, 7);
    wait_done(NB);
    total++;
    if (got_q.size() !== NB) begin bad++; $display("FAIL ramp_count got=%0d exp=%0d", got_q.size(), NB); end
    nf = 0;
    for (int n = 0; n < NB && n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== exp_q[n]) begin
        bad++;
        if (nf++ < 4) $display("FAIL ramp_beat n=%0d got=%h exp=%h", n, got_q[n], exp_q[n]);
      end
    end
`ifndef OPE_ROW_SUM_EN
    if (got_q.size() == NB) begin
      total++;
      if (got_q[35] !== {2'b00, 8'd6}) begin bad++; $display("FAIL ramp_b35 got=%h exp=006", got_q[35]); end
      total++;
      if (got_q[255] !== {2'b10, 8'd225}) begin bad++; $display("FAIL ramp_b255 got=%h exp=2e1", got_q[255]); end
    end
`endif
  endtask

  task automatic test_backpressure();
    int nf;
    clear_all();
    set_ramp();
    build_exp();
    rand_full = 1'b1;
    send_b();
    send_a(0, 7);
    wait_done(NB);
    rand_full = 1'b0;
    total++;
    if (got_q.size() !== NB) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), NB); end
    nf = 0;
    for (int n = 0; n < NB && n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== exp_q[n]) begin
        bad++;
        if (nf++ < 4) $display("FAIL bp_beat n=%0d got=%h exp=%h", n, got_q[n], exp_q[n]);
      end
    end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold violations=%0d exp=0", hold_err); end
  endtask

  task automatic test_reset_mid();
    int c;
    int nf;
    clear_all();
    set_ramp();
    abort = 1'b0;
    fork
      begin
        send_b();
        send_a(0, 7);
      end
    join_none
    c = 0;
    while (got_q.size() < 40 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    total++; if (c >= 3000) begin bad++; $display("FAIL mid_timeout beats=%0d exp=40", got_q.size()); end
    abort = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL mid_data got=%0d exp=0", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    clear_all();
    for (int k = 0; k < 16; k++) begin
      vb[k] = 4'(k);
      va[k] = 4'(15 - k);
    end
    build_exp();
    send_b();
    send_a(0, 7);
    wait_done(NB);
    total++;
    if (got_q.size() !== NB) begin bad++; $display("FAIL mid_count got=%0d exp=%0d", got_q.size(), NB); end
    nf = 0;
    for (int n = 0; n < NB && n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== exp_q[n]) begin
        bad++;
        if (nf++ < 4) $display("FAIL mid_beat n=%0d got=%h exp=%h", n, got_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_ignore_calc();
    int nf;
    clear_all();
    set_ramp();
    build_exp();
    send_b();
    send_a(0, 0);
    in_valid = 1'b1;
    in_data = 8'hFF;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL calc_ready got=%b exp=0", in_ready); end
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'd0;
    send_a(1, 7);
    wait_done(NB);
    total++;
    if (got_q.size() !== NB) begin bad++; $display("FAIL ign_count got=%0d exp=%0d", got_q.size(), NB); end
    nf = 0;
    for (int n = 0; n < NB && n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== exp_q[n]) begin
        bad++;
        if (nf++ < 4) $display("FAIL ign_beat n=%0d got=%h exp=%h", n, got_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nf;
    clear_all();
    set_ramp();
    build_exp();
    send_b();
    send_a(0, 7);
    set_max();
    build_exp();
    send_b();
    send_a(0, 7);
    wait_done(2 * NB);
    total++;
    if (got_q.size() !== 2 * NB) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2 * NB); end
    nf = 0;
    for (int n = 0; n < 2 * NB && n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== exp_q[n]) begin
        bad++;
        if (nf++ < 4) $display("FAIL b2b_beat n=%0d got=%h exp=%h", n, got_q[n], exp_q[n]);
      end
    end
  endtask

`ifdef OPE_ROW_SUM_EN
  task automatic test_row_sum();
    clear_all();
    set_ramp();
    va[0] = 4'd2;
    send_b();
    send_a(0, 7);
    wait_done(NB);
    total++;
    if (got_q.size() !== 272) begin bad++; $display("FAIL sum_count got=%0d exp=272", got_q.size()); end
    if (got_q.size() == 272) begin
      total++;
      if (got_q[16] !== {2'b01, 8'd240}) begin bad++; $display("FAIL sum_row0 got=%h exp=0f0", got_q[16]); end
      total++;
      if (got_q[271][9:8] !== 2'b11) begin bad++; $display("FAIL sum_last got=%b exp=11", got_q[271][9:8]); end
      total++;
      if (got_q[270][9] !== 1'b0) begin bad++; $display("FAIL sum_notlast got=%b exp=0", got_q[270][9]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_max();
    test_ramp();
    test_backpressure();
    test_reset_mid();
    test_ignore_calc();
    test_back_to_back();
`ifdef OPE_ROW_SUM_EN
    test_row_sum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
